// File: rtl/dc_avg_sched.sv
// Round-robin I/Q scheduler that shares one moving-average DC-removal datapath.
// Define SCHED_STATS_EN to build the input stall counter on stall_cnt_o.
module dc_avg_sched #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SAMPLES = 128,
    parameter int unsigned AVG_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid_i,
    input  logic [WIDTH-1:0] i_data_i,
    output logic             i_ready_o,
    input  logic             q_valid_i,
    input  logic [WIDTH-1:0] q_data_i,
    output logic             q_ready_o,
    output logic             avg_en_o,
    output logic             avg_ch_o,
    output logic [WIDTH-1:0] avg_data_o,
    input  logic [WIDTH-1:0] avg_data_i,
    output logic             i_valid_o,
    output logic [WIDTH-1:0] i_data_o,
    output logic             q_valid_o,
    output logic [WIDTH-1:0] q_data_o,
    input  logic             flush_i,
    output logic             warm_o,
    output logic [15:0]      stall_cnt_o
);

    localparam int unsigned CntW = $clog2(SAMPLES) + 1;
    localparam int unsigned LatW = (AVG_LAT > 1) ? $clog2(AVG_LAT + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(SAMPLES);
    localparam logic [LatW-1:0] LatLast = LatW'(AVG_LAT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRetire} state_e;

    state_e           state_q, state_d;
    logic             i_pend_q, i_pend_d;
    logic             q_pend_q, q_pend_d;
    logic [WIDTH-1:0] i_hold_q, i_hold_d;
    logic [WIDTH-1:0] q_hold_q, q_hold_d;
    logic             rr_q, rr_d;
    logic             grant_q, grant_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic             avg_en_q, avg_en_d;
    logic             avg_ch_q, avg_ch_d;
    logic [WIDTH-1:0] avg_data_q, avg_data_d;
    logic             i_valid_q, i_valid_d;
    logic [WIDTH-1:0] i_data_q, i_data_d;
    logic             q_valid_q, q_valid_d;
    logic [WIDTH-1:0] q_data_q, q_data_d;
    logic [CntW-1:0]  i_cnt_q, i_cnt_d;
    logic [CntW-1:0]  q_cnt_q, q_cnt_d;
    logic             warm_q, warm_d;

    logic i_acc, q_acc;
    logic retire_i, retire_q;
    logic i_avail, q_avail;
    logic pick_any, pick_ch;

    always_comb begin
        i_acc    = i_valid_i & ~i_pend_q;
        q_acc    = q_valid_i & ~q_pend_q;
        retire_i = (state_q == StRetire) & ~grant_q;
        retire_q = (state_q == StRetire) & grant_q;
        // The retiring channel's pend is still set this cycle; exclude it from arbitration.
        i_avail  = i_pend_q & ~retire_i;
        q_avail  = q_pend_q & ~retire_q;
        pick_any = i_avail | q_avail;
        pick_ch  = (i_avail & q_avail) ? rr_q : q_avail;
    end

    always_comb begin
        i_pend_d = i_acc | (i_pend_q & ~retire_i);
        q_pend_d = q_acc | (q_pend_q & ~retire_q);
        i_hold_d = i_acc ? i_data_i : i_hold_q;
        q_hold_d = q_acc ? q_data_i : q_hold_q;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        lat_d      = lat_q;
        avg_en_d   = 1'b0;
        avg_ch_d   = avg_ch_q;
        avg_data_d = avg_data_q;
        i_valid_d  = 1'b0;
        i_data_d   = i_data_q;
        q_valid_d  = 1'b0;
        q_data_d   = q_data_q;

        unique case (state_q)
            StIdle, StRetire: begin
                if (pick_any) begin
                    state_d    = StIssue;
                    avg_en_d   = 1'b1;
                    avg_ch_d   = pick_ch;
                    avg_data_d = pick_ch ? q_hold_q : i_hold_q;
                    grant_d    = pick_ch;
                    rr_d       = ~pick_ch;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StWait;
                lat_d   = LatW'(1);
            end
            StWait: begin
                if (lat_q == LatLast) begin
                    state_d = StRetire;
                    if (grant_q) begin
                        q_data_d  = avg_data_i;
                        q_valid_d = 1'b1;
                    end else begin
                        i_data_d  = avg_data_i;
                        i_valid_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        i_cnt_d = i_cnt_q;
        q_cnt_d = q_cnt_q;
        if (flush_i) begin
            i_cnt_d = '0;
            q_cnt_d = '0;
        end else begin
            if (retire_i && (i_cnt_q != CntMax)) i_cnt_d = i_cnt_q + CntW'(1);
            if (retire_q && (q_cnt_q != CntMax)) q_cnt_d = q_cnt_q + CntW'(1);
        end
        warm_d = (i_cnt_d == CntMax) && (q_cnt_d == CntMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            i_pend_q   <= 1'b0;
            q_pend_q   <= 1'b0;
            i_hold_q   <= '0;
            q_hold_q   <= '0;
            rr_q       <= 1'b0;
            grant_q    <= 1'b0;
            lat_q      <= '0;
            avg_en_q   <= 1'b0;
            avg_ch_q   <= 1'b0;
            avg_data_q <= '0;
            i_valid_q  <= 1'b0;
            i_data_q   <= '0;
            q_valid_q  <= 1'b0;
            q_data_q   <= '0;
            i_cnt_q    <= '0;
            q_cnt_q    <= '0;
            warm_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_pend_q   <= i_pend_d;
            q_pend_q   <= q_pend_d;
            i_hold_q   <= i_hold_d;
            q_hold_q   <= q_hold_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            lat_q      <= lat_d;
            avg_en_q   <= avg_en_d;
            avg_ch_q   <= avg_ch_d;
            avg_data_q <= avg_data_d;
            i_valid_q  <= i_valid_d;
            i_data_q   <= i_data_d;
            q_valid_q  <= q_valid_d;
            q_data_q   <= q_data_d;
            i_cnt_q    <= i_cnt_d;
            q_cnt_q    <= q_cnt_d;
            warm_q     <= warm_d;
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_ev;

    always_comb begin
        stall_ev = (i_valid_i & i_pend_q) | (q_valid_i & q_pend_q);
        stall_d  = stall_q;
        if (flush_i) begin
            stall_d = '0;
        end else if (stall_ev && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign i_ready_o  = ~i_pend_q;
    assign q_ready_o  = ~q_pend_q;
    assign avg_en_o   = avg_en_q;
    assign avg_ch_o   = avg_ch_q;
    assign avg_data_o = avg_data_q;
    assign i_valid_o  = i_valid_q;
    assign i_data_o   = i_data_q;
    assign q_valid_o  = q_valid_q;
    assign q_data_o   = q_data_q;
    assign warm_o     = warm_q;

endmodule

// File: tb/tb_dc_avg_sched.sv
// Bench for dc_avg_sched: vector table, hand-written corner sequences and a result scoreboard.
module tb_dc_avg_sched;

    localparam int WIDTH   = 16;
    localparam int SAMPLES = 128;
    localparam int AVG_LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid_i, q_valid_i, flush_i;
    logic [WIDTH-1:0] i_data_i, q_data_i, avg_data_i;
    logic             i_ready_o, q_ready_o, avg_en_o, avg_ch_o;
    logic [WIDTH-1:0] avg_data_o, i_data_o, q_data_o;
    logic             i_valid_o, q_valid_o, warm_o;
    logic [15:0]      stall_cnt_o;

    dc_avg_sched #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .AVG_LAT(AVG_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_valid_i(i_valid_i), .i_data_i(i_data_i), .i_ready_o(i_ready_o),
        .q_valid_i(q_valid_i), .q_data_i(q_data_i), .q_ready_o(q_ready_o),
        .avg_en_o(avg_en_o), .avg_ch_o(avg_ch_o), .avg_data_o(avg_data_o),
        .avg_data_i(avg_data_i),
        .i_valid_o(i_valid_o), .i_data_o(i_data_o),
        .q_valid_o(q_valid_o), .q_data_o(q_data_o),
        .flush_i(flush_i), .warm_o(warm_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Stand-in averager transfer function: I subtracts 63, Q adds 11 (mod 2^16).
    function automatic logic [15:0] avg_model(logic ch, logic [15:0] d);
        return ch ? d + 16'd11 : d - 16'd63;
    endfunction

    logic [15:0] exp_i[$];
    logic [15:0] exp_q[$];
    int          n_i_res = 0, n_q_res = 0;

    // Scoreboard push on accepted input.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_valid_i && i_ready_o) exp_i.push_back(avg_model(1'b0, i_data_i));
            if (q_valid_i && q_ready_o) exp_q.push_back(avg_model(1'b1, q_data_i));
        end
    end

    // Averager model: result valid exactly AVG_LAT(=1) cycle after the strobe, poison otherwise.
    logic        strobe_seen = 1'b0;
    logic [15:0] strobe_val  = '0;
    always @(negedge clk) begin
        strobe_seen = avg_en_o;
        if (avg_en_o) strobe_val = avg_model(avg_ch_o, avg_data_o);
    end
    always @(posedge clk) begin
        #1;
        avg_data_i = strobe_seen ? strobe_val : 16'hdead;
    end

    // Result monitor and saturation checks.
    logic sat_mode = 1'b0;
    logic have_last = 1'b0;
    logic last_ch = 1'b0;
    int   gap = 0;
    always @(negedge clk) begin
        if (i_valid_o) begin
            n_i_res++;
            if (exp_i.size() == 0) check("i_unexpected_result", 32'd1, 32'd0);
            else check("i_result", i_data_o, exp_i.pop_front());
        end
        if (q_valid_o) begin
            n_q_res++;
            if (exp_q.size() == 0) check("q_unexpected_result", 32'd1, 32'd0);
            else check("q_result", q_data_o, exp_q.pop_front());
        end
        if (sat_mode) begin
            gap++;
            if (avg_en_o) begin
                if (have_last) begin
                    check("sat_alternate", avg_ch_o, !last_ch);
                    check("sat_gap_ok", (gap <= AVG_LAT + 2), 32'd1);
                end
                have_last = 1'b1;
                last_ch   = avg_ch_o;
                gap       = 0;
            end
        end
    end

    task automatic feed_i(input int n);
        for (int k = 0; k < n; k++) begin
            int b;
            i_valid_i = 1'b1;
            i_data_i  = 16'($urandom);
            b = 0;
            do begin @(negedge clk); b++; end while (!i_ready_o && b < 50);
            if (!i_ready_o) begin
                check("feed_i_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        i_valid_i = 1'b0;
    endtask

    task automatic feed_q(input int n);
        for (int k = 0; k < n; k++) begin
            int b;
            q_valid_i = 1'b1;
            q_data_i  = 16'($urandom);
            b = 0;
            do begin @(negedge clk); b++; end while (!q_ready_o && b < 50);
            if (!q_ready_o) begin
                check("feed_q_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        q_valid_i = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1; flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0;
    endtask

    typedef struct {
        logic        ch;
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[6];
    int   stall_exp;
    int   base_i, base_q, b;

    initial begin
        tbl[0] = '{1'b0, 16'd100,  16'd37};
        tbl[1] = '{1'b1, 16'd100,  16'd111};
        tbl[2] = '{1'b0, 16'h8000, 16'h7fc1};
        tbl[3] = '{1'b1, 16'h7fff, 16'h800a};
        tbl[4] = '{1'b0, 16'h0000, 16'hffc1};
        tbl[5] = '{1'b1, 16'hfffb, 16'h0006};

        rst = 1'b1; flush_i = 1'b0;
        i_valid_i = 1'b0; q_valid_i = 1'b0; i_data_i = '0; q_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", i_ready_o, 32'd1);
        check("rst_q_ready", q_ready_o, 32'd1);
        check("rst_avg_en", avg_en_o, 32'd0);
        check("rst_avg_data", avg_data_o, 32'd0);
        check("rst_i_valid", i_valid_o, 32'd0);
        check("rst_q_data", q_data_o, 32'd0);
        check("rst_warm", warm_o, 32'd0);
        check("rst_stall", stall_cnt_o, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Single-channel transactions from idle.
        foreach (tbl[n]) begin
            @(posedge clk); #1;
            if (tbl[n].ch) begin q_valid_i = 1'b1; q_data_i = tbl[n].din; end
            else begin i_valid_i = 1'b1; i_data_i = tbl[n].din; end
            @(posedge clk); #1;
            i_valid_i = 1'b0; q_valid_i = 1'b0;
            @(negedge clk);
            check("vec_ready_low", tbl[n].ch ? q_ready_o : i_ready_o, 32'd0);
            @(negedge clk);
            check("vec_strobe", avg_en_o, 32'd1);
            check("vec_strobe_ch", avg_ch_o, tbl[n].ch);
            check("vec_strobe_data", avg_data_o, tbl[n].din);
            @(negedge clk);
            check("vec_strobe_one_cycle", avg_en_o, 32'd0);
            check("vec_data_hold", avg_data_o, tbl[n].din);
            @(negedge clk);
            check("vec_valid", tbl[n].ch ? q_valid_o : i_valid_o, 32'd1);
            check("vec_other_valid", tbl[n].ch ? i_valid_o : q_valid_o, 32'd0);
            check("vec_result", tbl[n].ch ? q_data_o : i_data_o, tbl[n].dout);
            @(negedge clk);
            check("vec_valid_pulse", tbl[n].ch ? q_valid_o : i_valid_o, 32'd0);
            check("vec_result_held", tbl[n].ch ? q_data_o : i_data_o, tbl[n].dout);
            check("vec_ready_back", tbl[n].ch ? q_ready_o : i_ready_o, 32'd1);
        end

        // Simultaneous offer right after reset: I first, Q three cycles later.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        i_valid_i = 1'b1; i_data_i = 16'h1234;
        q_valid_i = 1'b1; q_data_i = 16'h4321;
        @(posedge clk); #1;
        i_valid_i = 1'b0; q_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("both_first_en", avg_en_o, 32'd1);
        check("both_first_ch", avg_ch_o, 32'd0);
        check("both_first_data", avg_data_o, 32'h1234);
        @(negedge clk);
        @(negedge clk);
        check("both_mid_no_en", avg_en_o, 32'd0);
        @(negedge clk);
        check("both_second_en", avg_en_o, 32'd1);
        check("both_second_ch", avg_ch_o, 32'd1);
        check("both_second_data", avg_data_o, 32'h4321);
        repeat (5) @(negedge clk);

        // I held valid for 5 cycles while its sample waits behind Q.
        pulse_flush();
        @(posedge clk); #1; q_valid_i = 1'b1; q_data_i = 16'h0aaa;
        @(posedge clk); #1; q_valid_i = 1'b0; i_valid_i = 1'b1; i_data_i = 16'h0bbb;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready_low", i_ready_o, 32'd0);
            @(posedge clk); #1;
        end
        i_valid_i = 1'b0;
        @(negedge clk);
`ifdef SCHED_STATS_EN
        stall_exp = 5;
`else
        stall_exp = 0;
`endif
        check("stall_cnt", stall_cnt_o, stall_exp);
        repeat (8) @(negedge clk);

        // Saturation: both channels continuously valid.
        base_i = n_i_res; base_q = n_q_res;
        @(posedge clk); #1;
        sat_mode = 1'b1; have_last = 1'b0;
        fork
            feed_i(150);
            feed_q(150);
        join
        repeat (10) @(negedge clk);
        sat_mode = 1'b0;
        check("sat_i_count", n_i_res - base_i, 32'd150);
        check("sat_q_count", n_q_res - base_q, 32'd150);
        check("sat_i_drained", exp_i.size(), 32'd0);
        check("sat_q_drained", exp_q.size(), 32'd0);
        check("sat_warm", warm_o, 32'd1);

        // Warm-up threshold.
        pulse_flush();
        @(negedge clk);
        check("flush_warm_clear", warm_o, 32'd0);
        @(posedge clk); #1;
        fork
            feed_i(SAMPLES);
            feed_q(SAMPLES - 1);
        join
        repeat (10) @(negedge clk);
        check("warm_127_q", warm_o, 32'd0);
        @(posedge clk); #1;
        feed_q(1);
        b = 0;
        do begin @(negedge clk); b++; end while (!q_valid_o && b < 20);
        check("warm_last_q_seen", q_valid_o, 32'd1);
        check("warm_on_last_result", warm_o, 32'd0);
        @(negedge clk);
        check("warm_set", warm_o, 32'd1);
        pulse_flush();
        @(negedge clk);
        check("warm_flushed", warm_o, 32'd0);

        // Reset during WAIT discards the in-flight result.
        repeat (3) @(negedge clk);
        @(posedge clk); #1; i_valid_i = 1'b1; i_data_i = 16'h0777;
        @(posedge clk); #1; i_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        exp_i.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rstwait_i_valid", i_valid_o, 32'd0);
        check("rstwait_q_valid", q_valid_o, 32'd0);
        check("rstwait_avg_en", avg_en_o, 32'd0);
        check("rstwait_i_data", i_data_o, 32'd0);
        check("rstwait_avg_data", avg_data_o, 32'd0);
        check("rstwait_i_ready", i_ready_o, 32'd1);
        check("rstwait_q_ready", q_ready_o, 32'd1);
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
